// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_32
//  Description : Sequential restoring divider, one quotient bit per cycle.
//                valid/ready handshakes on the operand and result sides.
//                Optional signed two's-complement mode is enabled by defining
//                the macro DIV_SIGNED_EN; the default build is unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
`ifdef DIV_SIGNED_EN
        S_DONE = 2'd2,
        S_FIX  = 2'd3
`else
        S_DONE = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    // Working registers: r_quo starts as the dividend and fills with quotient
    // bits from the LSB as dividend bits are shifted out into r_rem.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_count;
    logic             r_dbz;

    logic             w_in_fire;
    logic             w_div_zero;
    logic             w_last_step;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_orig_dividend;

`ifdef DIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;

    // Magnitudes of the incoming operands; the most-negative value maps to
    // itself, which is the correct unsigned magnitude.
    assign w_dividend_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_divisor_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
    // r_quo still holds the dividend magnitude when a zero divisor is seen.
    assign w_orig_dividend = r_neg_r ? -r_quo : r_quo;
`else
    assign w_orig_dividend = r_quo;
`endif

    assign w_in_fire   = in_valid & in_ready;
    assign w_div_zero  = (r_div == '0);
    assign w_last_step = (r_count == c_last_step);

    // One restoring step. The shifted remainder is below 2*divisor, so the
    // difference lies strictly within +/-2^WIDTH and its top bit is the sign.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_div};
    assign w_trial_ok  = ~w_trial[WIDTH];
    assign w_rem_step  = w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_step  = {r_quo[WIDTH-2:0], w_trial_ok};

    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_div_zero) begin
                    w_next_state = S_DONE;
                end else if (w_last_step) begin
`ifdef DIV_SIGNED_EN
                    w_next_state = S_FIX;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
                w_next_state = S_DONE;
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_rem   <= '0;
                        r_count <= '0;
                        r_dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
                        r_quo   <= w_dividend_mag;
                        r_div   <= w_divisor_mag;
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
`else
                        r_quo   <= dividend;
                        r_div   <= divisor;
`endif
                    end
                end
                S_BUSY: begin
                    if (w_div_zero) begin
                        r_quo <= '1;
                        r_rem <= w_orig_dividend;
                        r_dbz <= 1'b1;
                    end else begin
                        r_rem   <= w_rem_step;
                        r_quo   <= w_quo_step;
                        r_count <= r_count + c_cnt_one;
                    end
                end
`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    if (r_neg_q) begin
                        r_quo <= -r_quo;
                    end
                    if (r_neg_r) begin
                        r_rem <= -r_rem;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider_32
//  Description : Self-checking bench for seq_divider_32 with directed cases
//                and randomized operands against an arithmetic reference.
//                Follows DIV_SIGNED_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider_32;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam int c_lat = W + 1;
`else
    localparam int c_lat = W;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests;
    int n_fail;

    seq_divider_32 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z);
`ifdef DIV_SIGNED_EN
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0]        most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (a == most_neg && b == '1) begin
            q = most_neg;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
`else
        z = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endtask

    // Present one operand pair for a single cycle (caller ensures IDLE).
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the handshake edge until out_valid; -1 on timeout.
    // With rand_bp set, out_ready and in_valid are toggled randomly meanwhile.
    task automatic wait_out(input bit rand_bp, output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (rand_bp) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                dividend  = $urandom;
                divisor   = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_tests++;
        if (quotient !== '0 || remainder !== '0) begin
            n_fail++; $display("FAIL reset_results: got q=%h r=%h want 0/0", quotient, remainder);
        end
        n_tests++;
        if (div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        drive_op(32'd100, 32'd7);
        wait_out(1'b0, lat);
        n_tests++;
        if (lat != c_lat) begin
            n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, c_lat);
        end
        n_tests++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL basic_100_7: got q=%0d r=%0d z=%b want 14/2/0",
                               quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_release: got out_valid=%b in_ready=%b want 0/1",
                               out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        drive_op(32'hFFFF_FFFF, 32'd1);
        wait_out(1'b0, lat);
        n_tests++;
        if (lat != c_lat || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_max_by_1: got lat=%0d q=%h r=%h z=%b want %0d/ffffffff/0/0",
                               lat, quotient, remainder, div_by_zero, c_lat);
        end
        @(posedge clk); #1;
        drive_op(32'd5, 32'd0);
        wait_out(1'b0, lat);
        n_tests++;
        if (lat != 1) begin
            n_fail++; $display("FAIL b2b_div0_latency: got %0d want 1", lat);
        end
        n_tests++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            n_fail++; $display("FAIL b2b_div0: got q=%h r=%0d z=%b want ffffffff/5/1",
                               quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int  lat;
        bit  held;
        out_ready = 1'b0;
        drive_op(32'd7, 32'd3);
        wait_out(1'b0, lat);
        n_tests++;
        if (lat != c_lat) begin
            n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, c_lat);
        end
        held = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            dividend = 32'd1000 + 32'(k);
            divisor  = 32'd9;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd2 ||
                remainder !== 32'd1 || div_by_zero !== 1'b0) held = 1'b0;
        end
        in_valid = 1'b0;
        n_tests++;
        if (!held) begin
            n_fail++; $display("FAIL bp_hold: got ov=%b ir=%b q=%0d r=%0d want 1/0/2/1",
                               out_valid, in_ready, quotient, remainder);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_restart: got in_ready=%b out_valid=%b want 1/0",
                               in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int  lat;
        bit  quiet;
        out_ready = 1'b1;
        drive_op(32'd1000, 32'd3);
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0 ||
            out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_immediate: got q=%h r=%h z=%b ov=%b ir=%b want 0/0/0/0/1",
                               quotient, remainder, div_by_zero, out_valid, in_ready);
        end
        #2;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++; $display("FAIL abort_quiet: got out_valid=%b in_ready=%b want 0/1",
                               out_valid, in_ready);
        end
        drive_op(32'd9, 32'd4);
        wait_out(1'b0, lat);
        n_tests++;
        if (lat != c_lat || quotient !== 32'd2 || remainder !== 32'd1) begin
            n_fail++; $display("FAIL abort_next_op: got lat=%0d q=%0d r=%0d want %0d/2/1",
                               lat, quotient, remainder, c_lat);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [W-1:0] qv [3];
        logic [W-1:0] rv [3];
        int           lat;
        av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;         qv[0] = 32'hFFFF_FFFD; rv[0] = 32'hFFFF_FFFF;
        av[1] = 32'd7;         bv[1] = 32'hFFFF_FFFE; qv[1] = 32'hFFFF_FFFD; rv[1] = 32'd1;
        av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF; qv[2] = 32'h8000_0000; rv[2] = 32'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_op(av[k], bv[k]);
            wait_out(1'b0, lat);
            n_tests++;
            if (lat != W + 1 || quotient !== qv[k] || remainder !== rv[k] || div_by_zero !== 1'b0) begin
                n_fail++; $display("FAIL signed_case%0d: got lat=%0d q=%h r=%h z=%b want %0d/%h/%h/0",
                                   k, lat, quotient, remainder, div_by_zero, W + 1, qv[k], rv[k]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        int           lat;
        int           sel;
        bit           held;
        bit           done;
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = 32'd1;
                3: a = $urandom_range(0, 255);
                4: begin a = 32'h8000_0000; b = '1; end
                5: b = a;
                6: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            ref_div(a, b, eq, er, ez);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want 1", i, in_ready);
            end
            drive_op(a, b);
            wait_out(1'b1, lat);
            n_tests++;
            if (lat != ((b == '0) ? 1 : c_lat)) begin
                n_fail++; $display("FAIL rand_latency[%0d]: %h/%h got %0d want %0d",
                                   i, a, b, lat, (b == '0) ? 1 : c_lat);
            end
            n_tests++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                n_fail++; $display("FAIL rand_result[%0d]: %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                                   i, a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
            held = 1'b1;
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                if (out_valid !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== ez)
                    held = 1'b0;
                out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                dividend  = $urandom;
                divisor   = $urandom;
                done      = out_ready;
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            n_tests++;
            if (!held || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rand_hold_release[%0d]: held=%b in_ready=%b out_valid=%b want 1/1/0",
                                   i, held, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
